// File: rtl/noc_pkg.sv
// Shared packet layout, mode/state encodings and small helpers for the NoC
// traffic generator and its matching sink.
package noc_pkg;

  localparam int PKT_W    = 11;
  localparam int DEST_MSB = 10;
  localparam int DEST_LSB = 7;
  localparam int SRC_MSB  = 6;
  localparam int SRC_LSB  = 3;
  localparam int SEQ_MSB  = 2;
  localparam int SEQ_LSB  = 0;

  typedef enum logic [1:0] {
    MODE_RANDOM = 2'd0,
    MODE_FIXED  = 2'd1,
    MODE_RR     = 2'd2,
    MODE_RSVD   = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_GAP  = 2'd1,
    ST_SEND = 2'd2,
    ST_DONE = 2'd3
  } tg_state_e;

  function automatic logic [PKT_W-1:0] pack_pkt(input logic [3:0] dest,
                                                input logic [3:0] src,
                                                input logic [2:0] seq);
    logic [PKT_W-1:0] p;
    p                    = {PKT_W{1'b0}};
    p[DEST_MSB:DEST_LSB] = dest;
    p[SRC_MSB:SRC_LSB]   = src;
    p[SEQ_MSB:SEQ_LSB]   = seq;
    return p;
  endfunction

  // Fibonacci step, taps 7/5/4/3, shifting left into bit 0.
  function automatic logic [7:0] lfsr_step(input logic [7:0] l);
    return {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
  endfunction

  // Random destination from the low nibble, nudged off our own address.
  function automatic logic [3:0] rand_dest(input logic [7:0] l, input logic [3:0] self_id);
    return (l[3:0] == self_id) ? (l[3:0] ^ 4'b0001) : l[3:0];
  endfunction

  function automatic logic [3:0] rr_next(input logic [3:0] r, input logic [3:0] self_id);
    logic [3:0] n;
    n = r + 4'd1;
    return (n == self_id) ? (n + 4'd1) : n;
  endfunction

endpackage

// File: rtl/noc_lfsr8.sv
// 8-bit Fibonacci LFSR that advances only when step is high; a zero seed is
// replaced by 8'h01 so the register can never lock up.
module noc_lfsr8
  import noc_pkg::*;
#(
  parameter logic [7:0] SEED = 8'hA5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       step,
  output logic [7:0] q
);

  localparam logic [7:0] INIT = (SEED == 8'h00) ? 8'h01 : SEED;

  always_ff @(posedge clk) begin
    if (reset) begin
      q <= INIT;
    end else if (step) begin
      q <= lfsr_step(q);
    end
  end

endmodule

// File: rtl/noc_traffic_gen.sv
// Per-node traffic source: injects a programmed number of {dest, src, seq}
// packets on a valid/ready handshake with a programmable inter-packet gap.
module noc_traffic_gen
  import noc_pkg::*;
#(
  parameter logic [3:0] MY_IP     = 4'b0000,
  parameter logic [7:0] LFSR_SEED = 8'hA5,
  parameter int         CNT_W     = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       mode,
  input  logic [3:0]       fixed_dest,
  input  logic [CNT_W-1:0] num_pkts,
  input  logic [CNT_W-1:0] gap_cfg,
  output logic [PKT_W-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] sent_count
);

  localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  tg_state_e        state;
  mode_e            mode_q;
  logic [3:0]       fixed_q;
  logic [CNT_W-1:0] num_q;
  logic [CNT_W-1:0] gap_q;
  logic [CNT_W-1:0] gap_cnt;
  logic [2:0]       seq;
  logic [3:0]       rr_dest;
  logic [7:0]       lfsr_q;

  logic             hs;
  logic [7:0]       lfsr_nxt;
  logic [3:0]       rr_nxt;
  logic [2:0]       seq_nxt;
  mode_e            sel_mode;
  logic [3:0]       sel_fixed;
  logic [3:0]       nxt_dest;
  logic [PKT_W-1:0] nxt_pkt;

  noc_lfsr8 #(.SEED(LFSR_SEED)) u_lfsr (
    .clk   (clk),
    .reset (reset),
    .step  (hs),
    .q     (lfsr_q)
  );

  // Build the packet that would be offered next; on a handshake this looks one
  // step ahead so a back-to-back packet uses the advanced seq/LFSR/rr values.
  always_comb begin
    hs        = out_valid & out_ready;
    lfsr_nxt  = lfsr_q;
    rr_nxt    = rr_dest;
    seq_nxt   = seq;
    sel_mode  = mode_q;
    sel_fixed = fixed_q;
    nxt_dest  = 4'd0;
    if (hs) begin
      lfsr_nxt = lfsr_step(lfsr_q);
      rr_nxt   = rr_next(rr_dest, MY_IP);
      seq_nxt  = seq + 3'd1;
    end else begin
      lfsr_nxt = lfsr_q;
      rr_nxt   = rr_dest;
      seq_nxt  = seq;
    end
    if (state == ST_IDLE) begin
      sel_mode  = mode_e'(mode);
      sel_fixed = fixed_dest;
    end else begin
      sel_mode  = mode_q;
      sel_fixed = fixed_q;
    end
    case (sel_mode)
      MODE_FIXED: nxt_dest = sel_fixed;
      MODE_RR:    nxt_dest = rr_nxt;
      default:    nxt_dest = rand_dest(lfsr_nxt, MY_IP);
    endcase
    nxt_pkt = pack_pkt(nxt_dest, MY_IP, seq_nxt);
  end

  // Run-control FSM with registered handshake, status and packet outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      mode_q     <= MODE_RANDOM;
      fixed_q    <= 4'd0;
      num_q      <= {CNT_W{1'b0}};
      gap_q      <= {CNT_W{1'b0}};
      gap_cnt    <= {CNT_W{1'b0}};
      seq        <= 3'd0;
      rr_dest    <= MY_IP + 4'd1;
      out_data   <= {PKT_W{1'b0}};
      out_valid  <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      sent_count <= {CNT_W{1'b0}};
    end else begin
      done <= 1'b0;
      if (hs) begin
        seq     <= seq_nxt;
        rr_dest <= rr_nxt;
      end
      case (state)
        ST_IDLE: begin
          if (start) begin
            mode_q     <= mode_e'(mode);
            fixed_q    <= fixed_dest;
            num_q      <= num_pkts;
            gap_q      <= gap_cfg;
            sent_count <= {CNT_W{1'b0}};
            if (num_pkts == {CNT_W{1'b0}}) begin
              state <= ST_DONE;
              done  <= 1'b1;
            end else if (gap_cfg == {CNT_W{1'b0}}) begin
              state     <= ST_SEND;
              busy      <= 1'b1;
              out_valid <= 1'b1;
              out_data  <= nxt_pkt;
            end else begin
              state   <= ST_GAP;
              busy    <= 1'b1;
              gap_cnt <= gap_cfg;
            end
          end
        end
        ST_GAP: begin
          if (gap_cnt == ONE) begin
            state     <= ST_SEND;
            out_valid <= 1'b1;
            out_data  <= nxt_pkt;
          end else begin
            gap_cnt <= gap_cnt - ONE;
          end
        end
        ST_SEND: begin
          if (hs) begin
            sent_count <= sent_count + ONE;
            if ((sent_count + ONE) == num_q) begin
              state     <= ST_DONE;
              out_valid <= 1'b0;
              busy      <= 1'b0;
              done      <= 1'b1;
            end else if (gap_q == {CNT_W{1'b0}}) begin
              out_data <= nxt_pkt;
            end else begin
              state     <= ST_GAP;
              out_valid <= 1'b0;
              gap_cnt   <= gap_q;
            end
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state     <= ST_IDLE;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule
